// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch bus: instruction/operand inputs toward the resolver and the
// redirect, stall and counter outputs back to fetch.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [2:0]        id_brType;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_imm;
  logic [3:0]        id_cond;
  logic [3:0]        flags_nzcv;
  logic              op_zero;
  logic              op_ready;
  logic              stall_o;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_ifid;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  taken_cnt;
  logic [1:0]        dbg_state;

  // Handshake: a branch is consumed in a cycle where id_valid=1, the class is
  // valid and stall_o=0; while stall_o=1 the ID stage holds its inputs stable.
  modport slave (
    input  id_valid, id_brType, id_pc, id_imm, id_cond, flags_nzcv,
           op_zero, op_ready,
    output stall_o, redirect, redirect_pc, flush_ifid, branch_cnt,
           taken_cnt, dbg_state
  );

  modport master (
    output id_valid, id_brType, id_pc, id_imm, id_cond, flags_nzcv,
           op_zero, op_ready,
    input  stall_o, redirect, redirect_pc, flush_ifid, branch_cnt,
           taken_cnt, dbg_state
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves B / CBZ / CBNZ / B.cond in ID under predict-not-taken, stalling on
// late CBZ/CBNZ operands and issuing a one-cycle redirect + IF/ID flush.
module branch_resolve_unit #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_resolve_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_n, w_z, w_c, w_v;
  logic              w_cond_true;
  logic              w_is_branch;
  logic              w_is_cb;
  logic              w_taken;
  logic              w_resolve;
  logic              w_stall;
  logic [ADDR_W-1:0] w_target;

  assign w_n = bus.flags_nzcv[3];
  assign w_z = bus.flags_nzcv[2];
  assign w_c = bus.flags_nzcv[1];
  assign w_v = bus.flags_nzcv[0];

  assign w_target = bus.id_pc + (bus.id_imm << 2);

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.id_cond)
      4'h0:    w_cond_true = w_z;
      4'h1:    w_cond_true = !w_z;
      4'h2:    w_cond_true = w_c;
      4'h3:    w_cond_true = !w_c;
      4'h4:    w_cond_true = w_n;
      4'h5:    w_cond_true = !w_n;
      4'h6:    w_cond_true = w_v;
      4'h7:    w_cond_true = !w_v;
      4'h8:    w_cond_true = w_c && !w_z;
      4'h9:    w_cond_true = !(w_c && !w_z);
      4'hA:    w_cond_true = (w_n == w_v);
      4'hB:    w_cond_true = (w_n != w_v);
      4'hC:    w_cond_true = !w_z && (w_n == w_v);
      4'hD:    w_cond_true = !(!w_z && (w_n == w_v));
      default: w_cond_true = 1'b1;
    endcase
  end

  // Classes 101-111 fall through as "no branch".
  always_comb begin
    w_is_branch = 1'b0;
    w_is_cb     = 1'b0;
    w_taken     = 1'b0;
    if (bus.id_valid) begin
      case (bus.id_brType)
        3'b001: begin
          w_is_branch = 1'b1;
          w_taken     = 1'b1;
        end
        3'b010: begin
          w_is_branch = 1'b1;
          w_is_cb     = 1'b1;
          w_taken     = bus.op_zero;
        end
        3'b011: begin
          w_is_branch = 1'b1;
          w_is_cb     = 1'b1;
          w_taken     = !bus.op_zero;
        end
        3'b100: begin
          w_is_branch = 1'b1;
          w_taken     = w_cond_true;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_resolve = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_branch) begin
          if (w_is_cb && !bus.op_ready) begin
            w_stall = 1'b1;
            w_next  = S_WAIT;
          end else begin
            w_resolve = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A killed or vanished instruction drops out without being counted.
        if (!w_is_branch) begin
          w_next = S_IDLE;
        end else if (w_is_cb && !bus.op_ready) begin
          w_stall = 1'b1;
        end else begin
          w_resolve = 1'b1;
        end
      end
      S_REDIR: begin
        // ID holds the flush shadow this cycle; it is ignored entirely.
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_resolve) begin
      w_next = w_taken ? S_REDIR : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_taken_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_resolve) begin
        if (r_branch_cnt != CNT_MAX) begin
          r_branch_cnt <= r_branch_cnt + 1'b1;
        end
        if (w_taken) begin
          r_redirect_pc <= w_target;
          if (r_taken_cnt != CNT_MAX) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Stall is combinational on live ID inputs, so it is gated off during reset.
  assign bus.stall_o     = w_stall && reset_n;
  assign bus.redirect    = (r_state == S_REDIR);
  assign bus.flush_ifid  = (r_state == S_REDIR);
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.taken_cnt   = r_taken_cnt;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a full-width instance plus a 4-bit
// counter instance share stimulus; redirects are checked against an expected queue.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ADDR_W(64), .CNT_W(32)) bm ();
  branch_resolve_unit_if #(.ADDR_W(64), .CNT_W(4))  bs ();

  branch_resolve_unit #(.ADDR_W(64), .CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bm.slave)
  );

  branch_resolve_unit #(.ADDR_W(64), .CNT_W(4)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bs.slave)
  );

  logic [63:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned m_branch = 0;
  int unsigned m_taken  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [3:0] cond,
                       input logic [3:0] nzcv, input logic oz, input logic ordy);
    bm.id_valid = v;  bs.id_valid = v;
    bm.id_brType = t; bs.id_brType = t;
    bm.id_pc = pc;    bs.id_pc = pc;
    bm.id_imm = imm;  bs.id_imm = imm;
    bm.id_cond = cond; bs.id_cond = cond;
    bm.flags_nzcv = nzcv; bs.flags_nzcv = nzcv;
    bm.op_zero = oz;  bs.op_zero = oz;
    bm.op_ready = ordy; bs.op_ready = ordy;
  endtask

  task automatic idle_in();
    drive(1'b0, 3'b000, 64'h0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    int unsigned sat_b, sat_t;
    sat_b = (m_branch > 15) ? 15 : m_branch;
    sat_t = (m_taken > 15) ? 15 : m_taken;
    chk({tag, " branch_cnt"}, 64'(bm.branch_cnt), 64'(m_branch));
    chk({tag, " taken_cnt"}, 64'(bm.taken_cnt), 64'(m_taken));
    chk({tag, " sat branch_cnt"}, 64'(bs.branch_cnt), 64'(sat_b));
    chk({tag, " sat taken_cnt"}, 64'(bs.taken_cnt), 64'(sat_t));
  endtask

  // Present a branch that can resolve immediately, then clear ID and let any
  // redirect cycle pass.
  task automatic resolve_now(input string name, input logic [2:0] t, input logic [63:0] pc,
                             input logic [63:0] imm, input logic [3:0] cond,
                             input logic [3:0] nzcv, input logic oz, input logic exp_taken);
    drive(1'b1, t, pc, imm, cond, nzcv, oz, 1'b1);
    #1;
    chk({name, " stall"}, 64'(bm.stall_o), 64'h0);
    m_branch++;
    if (exp_taken) begin
      m_taken++;
      exp_q.push_back(pc + (imm << 2));
    end
    step();
    idle_in();
    if (exp_taken) step();
  endtask

  // Monitor: every redirect pulse must match the oldest expected target.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bm.redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect", bm.redirect_pc);
        end else begin
          chk("redirect_pc", bm.redirect_pc, exp_q.pop_front());
          chk("flush_with_redirect", 64'(bm.flush_ifid), 64'h1);
        end
      end else if (bm.flush_ifid) begin
        checks++;
        failures++;
        $display("FAIL lone_flush: got flush_ifid=1 expected 0");
      end
    end
  end

  logic [15:0] sweep_mask [5];
  logic [3:0]  sweep_nzcv [5];

  initial begin
    sweep_nzcv[0] = 4'b0000; sweep_mask[0] = 16'hD6AA;
    sweep_nzcv[1] = 4'b0100; sweep_mask[1] = 16'hE6A9;
    sweep_nzcv[2] = 4'b1001; sweep_mask[2] = 16'hD65A;
    sweep_nzcv[3] = 4'b0110; sweep_mask[3] = 16'hE6A5;
    sweep_nzcv[4] = 4'b0010; sweep_mask[4] = 16'hD5A6;

    // Reset: CBZ with unready operand must not stall while in reset.
    reset_n = 1'b0;
    drive(1'b1, 3'b010, 64'h100, 64'h1, 4'h0, 4'h0, 1'b1, 1'b0);
    #2;
    chk("reset stall", 64'(bm.stall_o), 64'h0);
    chk("reset redirect", 64'(bm.redirect), 64'h0);
    chk("reset redirect_pc", bm.redirect_pc, 64'h0);
    check_cnt("reset");
    step();
    step();
    idle_in();
    reset_n = 1'b1;
    step();
    chk("post-reset state", 64'(bm.dbg_state), 64'h0);

    // Taken CBZ with operand ready.
    resolve_now("cbz_taken", 3'b010, 64'h1000, 64'h4, 4'h0, 4'h0, 1'b1, 1'b1);
    check_cnt("cbz_taken");

    // Stalled CBNZ: three stall cycles, then resolve with a negative offset.
    drive(1'b1, 3'b011, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 4'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("cbnz stall cyc%0d", i), 64'(bm.stall_o), 64'h1);
      step();
    end
    chk("cbnz wait state", 64'(bm.dbg_state), 64'h1);
    drive(1'b1, 3'b011, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 4'h0, 4'h0, 1'b0, 1'b1);
    #1;
    chk("cbnz release stall", 64'(bm.stall_o), 64'h0);
    exp_q.push_back(64'h1FF8);
    m_branch++;
    m_taken++;
    step();
    idle_in();
    #1;
    chk("cbnz redir stall", 64'(bm.stall_o), 64'h0);
    step();
    check_cnt("cbnz");

    // Killed in WAIT: nothing counted, no redirect.
    drive(1'b1, 3'b010, 64'h3000, 64'h8, 4'h0, 4'h0, 1'b1, 1'b0);
    #1;
    chk("kill stall", 64'(bm.stall_o), 64'h1);
    step();
    idle_in();
    #1;
    chk("kill unstall", 64'(bm.stall_o), 64'h0);
    step();
    chk("kill state", 64'(bm.dbg_state), 64'h0);
    check_cnt("kill");

    // B.cond sweep.
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 16; c++) begin
        resolve_now($sformatf("bcond p%0d c%0d", p, c), 3'b100,
                    64'h4000 + 64'(c * 16), 64'(p * 16 + c + 1), 4'(c),
                    sweep_nzcv[p], 1'b0, sweep_mask[p][c]);
      end
      check_cnt($sformatf("bcond p%0d", p));
    end

    // Flush shadow: CBZ in the REDIR cycle is ignored, the next one resolves.
    drive(1'b1, 3'b001, 64'h8000, 64'h10, 4'h0, 4'h0, 1'b0, 1'b1);
    exp_q.push_back(64'h8040);
    m_branch++;
    m_taken++;
    step();
    drive(1'b1, 3'b010, 64'h9000, 64'h8, 4'h0, 4'h0, 1'b1, 1'b0);
    #1;
    chk("shadow stall", 64'(bm.stall_o), 64'h0);
    chk("shadow redirect", 64'(bm.redirect), 64'h1);
    step();
    drive(1'b1, 3'b010, 64'h9100, 64'h2, 4'h0, 4'h0, 1'b1, 1'b1);
    exp_q.push_back(64'h9108);
    m_branch++;
    m_taken++;
    #1;
    chk("after shadow stall", 64'(bm.stall_o), 64'h0);
    step();
    idle_in();
    step();
    check_cnt("shadow");

    // Reset during REDIR drops the pulse and clears counters asynchronously.
    drive(1'b1, 3'b001, 64'hA000, 64'h1, 4'h0, 4'h0, 1'b0, 1'b1);
    step();
    idle_in();
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    m_branch = 0;
    m_taken  = 0;
    #1;
    chk("redir reset redirect", 64'(bm.redirect), 64'h0);
    chk("redir reset flush", 64'(bm.flush_ifid), 64'h0);
    check_cnt("redir reset");
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("redir reset state", 64'(bm.dbg_state), 64'h0);

    // Saturation of the 4-bit instance over 20 taken B branches.
    for (int i = 0; i < 20; i++) begin
      resolve_now($sformatf("sat b%0d", i), 3'b001, 64'h100 * 64'(i), 64'(i), 4'h0,
                  4'h0, 1'b0, 1'b1);
      if (i == 9) check_cnt("sat mid");
    end
    check_cnt("sat end");

    // Target wraps modulo 2^64.
    resolve_now("wrap", 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 4'h0, 4'h0, 1'b0, 1'b1);
    step();
    step();
    chk("exp_q drained", 64'(exp_q.size()), 64'h0);
    check_cnt("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage consumer of the CBZ zero flag and the NZCV flags.
- Evaluates B, CBZ, CBNZ and B.cond under a static predict-not-taken policy.
- Stalls while a CBZ/CBNZ operand is not yet forwardable.
- Issues a one-cycle PC redirect plus IF/ID flush on a taken branch, and keeps saturating branch/taken performance counters.

Parameters:
- ADDR_W, 64, PC/target width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_brType  in  3  branch class: 000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond; 101-111 are treated as none.
- id_pc  in  ADDR_W  PC of the ID instruction.
- id_imm  in  ADDR_W  sign-extended word offset.
- id_cond  in  4  B.cond condition code.
- flags_nzcv  in  4  forwarded flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- op_zero  in  1  zero flag of the forwarded Rt; meaningful only when op_ready=1.
- op_ready  in  1  Rt value is forwardable this cycle.
- stall_o  out  1  freeze PC and IF/ID.
- redirect  out  1  load redirect_pc into the PC.
- redirect_pc  out  ADDR_W  branch target.
- flush_ifid  out  1  squash the IF/ID register.
- branch_cnt  out  CNT_W  branches resolved.
- taken_cnt  out  CNT_W  branches taken.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; redirect, flush_ifid, redirect_pc, branch_cnt and taken_cnt all 0. stall_o is 0 while reset_n=0.
- Target arithmetic: target = id_pc + (id_imm << 2), modulo 2^ADDR_W. No overflow detection.
- Condition evaluation:
  - B: always taken.
  - CBZ: taken iff op_zero. CBNZ: taken iff !op_zero.
  - B.cond: EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)); 1110 and 1111 always.
  - B and B.cond never stall.
- A branch is "presented" when id_valid=1 and id_brType is a valid class. State machine:
  - IDLE, branch presented:
    - CBZ/CBNZ with op_ready=0: stall_o=1 combinationally the same cycle; go to WAIT.
    - Otherwise: resolve this cycle.
  - WAIT: stall_o=1 while op_ready=0. Upstream holds ID inputs stable; the unit uses the live ID inputs. When op_ready=1: stall_o=0, resolve this cycle.
  - Resolve:
    - branch_cnt += 1.
    - If taken: taken_cnt += 1, redirect_pc <= target, go to REDIR.
    - If not taken: go to IDLE, no redirect.
  - REDIR (exactly 1 cycle): redirect=1, flush_ifid=1, redirect_pc valid, stall_o=0. ID inputs this cycle belong to the flush shadow and are ignored: no resolve, no counting, no stall. Next state IDLE.
- Latency: a taken branch resolved at edge N asserts redirect and flush at cycle N+1 for one cycle.
- redirect_pc holds its last target outside REDIR.
- Back-to-back: a branch presented in the cycle immediately after REDIR is evaluated normally.
- Counters saturate at 2^CNT_W-1. taken_cnt never exceeds branch_cnt.
- id_valid=0 or brType none in WAIT: return to IDLE, nothing counted (the upstream instruction was killed).
- Mid-operation reset in WAIT or REDIR: immediate IDLE; the redirect pulse is dropped.

Test Plan:
- Reset: reset_n=0 during REDIR -> redirect=0, flush_ifid=0, counters=0 asynchronously; after release, state IDLE with no spurious pulse.
- Taken CBZ, operand ready: id_pc=0x1000, id_imm=4, op_zero=1, op_ready=1 -> next cycle redirect=1, flush_ifid=1, redirect_pc=0x1010 for one cycle; branch_cnt=1, taken_cnt=1.
- Stalled CBNZ: op_ready=0 for 3 cycles, then op_ready=1 with op_zero=0, id_imm=-2, id_pc=0x2000 -> stall_o=1 for exactly 3 cycles; then redirect_pc=0x1FF8 with a single redirect pulse.
- B.cond sweep: all 16 codes against NZCV=0000, 0100, 1001, 0110 -> taken matches the decode table; not-taken cases produce no redirect and increment branch_cnt only.
- Shadow: branch B in REDIR cycle followed by CBZ op_zero=1 in ID -> the shadow instruction is ignored (counters unchanged by it); the next-cycle branch resolves normally.
- Saturation: CNT_W=4, 20 taken B branches -> both counters hold at 15; target wrap: id_pc=0xFFFF_FFFF_FFFF_FFFC, id_imm=1 -> redirect_pc=0.
